// File: rtl/io_read_arbiter_pkg.sv
// Shared types for the I/O read arbiter: FSM states and source indices.
package common;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_SETTLE,
        ARB_DRIVE,
        ARB_NODRV,
        ARB_GAP
    } io_arb_state_t;

    localparam int IO_SRC_KEMPSTON = 0;
    localparam int IO_SRC_FE       = 1;
    localparam int IO_SRC_FF       = 2;
    localparam int IO_SRC_EXT      = 3;

endpackage

// File: rtl/cpu_bus.sv
// CPU bus signals seen by the I/O read path.
interface cpu_bus;

    logic ioreq;
    logic rd;

    modport arb (
        input ioreq,
        input rd
    );

endinterface

// File: rtl/io_read_arbiter_prio.sv
// Lowest-set-bit one-hot select with a "more than one request" flag.
module prio_onehot
    import common::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] onehot,
    output logic         multi
);

    assign onehot = req & (~req + N'(1));
    assign multi  = |(req & ~onehot);

endmodule

// File: rtl/io_read_arbiter.sv
// Fixed-priority arbiter for the CPU I/O read data bus with settle window,
// post-cycle gap and saturating collision log.
module io_read_arbiter
    import common::*;
#(
    parameter int N_SRC  = 4,
    parameter int SETTLE = 2,
    parameter int GAP    = 1
) (
    input  logic               clk28,
    input  logic               rst_n,
    cpu_bus.arb                bus,
    input  logic [N_SRC-1:0]   src_active,
    input  logic [8*N_SRC-1:0] src_data,
    input  logic [N_SRC-1:0]   src_mask,
    input  logic               collision_clr,
    output logic [7:0]         d_out,
    output logic               d_out_active,
    output logic [N_SRC-1:0]   grant,
    output logic               collision,
    output logic [7:0]         collision_count
);

    localparam int CMAX = (SETTLE > GAP) ? SETTLE : GAP;
    localparam int CW   = $clog2(CMAX + 1);

    io_arb_state_t  state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           cyc;
    logic           decide;
    logic           drop;
    logic [N_SRC-1:0] m;
    logic [N_SRC-1:0] sel;
    logic           multi;
    logic [7:0]     sel_byte;

    assign cyc = bus.ioreq && bus.rd;
    assign m   = src_active & src_mask;

    prio_onehot #(.N(N_SRC)) u_prio (
        .req    (m),
        .onehot (sel),
        .multi  (multi)
    );

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel[i]) sel_byte = src_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        decide  = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (cyc) begin
                    state_d = ARB_SETTLE;
                    cnt_d   = '0;
                end
            end
            ARB_SETTLE: begin
                if (!cyc) begin
                    state_d = ARB_IDLE;
                end else if (cnt_q == CW'(SETTLE - 1)) begin
                    decide  = 1'b1;
                    state_d = (|m) ? ARB_DRIVE : ARB_NODRV;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ARB_DRIVE: begin
                if (!cyc) begin
                    drop    = 1'b1;
                    state_d = ARB_GAP;
                    cnt_d   = '0;
                end
            end
            ARB_NODRV: begin
                if (!cyc) begin
                    state_d = ARB_GAP;
                    cnt_d   = '0;
                end
            end
            ARB_GAP: begin
                if (cnt_q == CW'(GAP - 1)) begin
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Granted byte is captured once and frozen until the read cycle ends.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            d_out        <= 8'hFF;
            d_out_active <= 1'b0;
            grant        <= '0;
        end else if (decide && |m) begin
            d_out        <= sel_byte;
            d_out_active <= 1'b1;
            grant        <= sel;
        end else if (drop) begin
            d_out_active <= 1'b0;
            grant        <= '0;
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            collision       <= 1'b0;
            collision_count <= '0;
        end else begin
            collision <= decide && multi;
            if (collision_clr) begin
                collision_count <= '0;
            end else if (decide && multi && collision_count != 8'hFF) begin
                collision_count <= collision_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_io_read_arbiter.sv
// Self-checking bench: directed vector table, corner sequences, random vs model.
module tb_io_read_arbiter;

    localparam int SETTLE = 2;
    localparam int GAP    = 1;

    logic        clk28;
    logic        rst_n;
    logic [3:0]  src_active;
    logic [31:0] src_data;
    logic [3:0]  src_mask;
    logic        collision_clr;
    logic [7:0]  d_out;
    logic        d_out_active;
    logic [3:0]  grant;
    logic        collision;
    logic [7:0]  collision_count;

    cpu_bus bus_if ();

    io_read_arbiter #(.N_SRC(4), .SETTLE(SETTLE), .GAP(GAP)) dut (
        .clk28           (clk28),
        .rst_n           (rst_n),
        .bus             (bus_if.arb),
        .src_active      (src_active),
        .src_data        (src_data),
        .src_mask        (src_mask),
        .collision_clr   (collision_clr),
        .d_out           (d_out),
        .d_out_active    (d_out_active),
        .grant           (grant),
        .collision       (collision),
        .collision_count (collision_count)
    );

    initial clk28 = 1'b0;
    always #5 clk28 = ~clk28;

    int checks = 0;
    int failures = 0;

    // Transaction-level reference: tracks when a read cycle was accepted,
    // whether its decision has happened, and the earliest edge a new one may start.
    int         t;
    bit         r_acc;
    bit         r_dec;
    int         r_start;
    int         r_ready;
    logic       r_act;
    logic [3:0] r_grant;
    logic [7:0] r_dout;
    logic       r_coll;
    logic [7:0] r_cnt;

    typedef struct {
        logic        cyc;
        logic [3:0]  act;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        clr;
        logic        e_act;
        logic [3:0]  e_grant;
        logic [7:0]  e_dout;
        logic        e_coll;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        t = 0; r_acc = 0; r_dec = 0; r_start = 0; r_ready = 0;
        r_act = 0; r_grant = '0; r_dout = 8'hFF; r_coll = 0; r_cnt = '0;
    endtask

    task automatic model_edge(input logic cyc, input logic [3:0] act,
                              input logic [31:0] data, input logic [3:0] mask,
                              input logic clr);
        logic [3:0] mm;
        bit inc;
        inc = 0;
        r_coll = 0;
        mm = act & mask;
        if (!r_acc) begin
            if (t >= r_ready && cyc) begin
                r_acc = 1; r_dec = 0; r_start = t;
            end
        end else if (!r_dec) begin
            if (!cyc) begin
                r_acc = 0; r_ready = t + 1;
            end else if (t - r_start == SETTLE) begin
                r_dec = 1;
                for (int i = 3; i >= 0; i--) begin
                    if (mm[i]) begin
                        r_grant = 4'(1 << i);
                        r_dout = data[8*i +: 8];
                        r_act = 1;
                    end
                end
                if ($countones(mm) > 1) begin
                    r_coll = 1; inc = 1;
                end
            end
        end else if (!cyc) begin
            r_act = 0; r_grant = '0; r_acc = 0; r_ready = t + GAP + 1;
        end
        if (clr) r_cnt = '0;
        else if (inc && r_cnt != 8'hFF) r_cnt = r_cnt + 8'd1;
        t++;
    endtask

    task automatic step(input logic cyc, input logic [3:0] act,
                        input logic [31:0] data, input logic [3:0] mask,
                        input logic clr);
        bus_if.ioreq = cyc;
        bus_if.rd = cyc;
        src_active = act;
        src_data = data;
        src_mask = mask;
        collision_clr = clr;
        @(posedge clk28);
        model_edge(cyc, act, data, mask, clr);
        #1;
    endtask

    task automatic chk_model(input string tag);
        check({tag, ".active"}, 32'(d_out_active), 32'(r_act));
        check({tag, ".grant"}, 32'(grant), 32'(r_grant));
        check({tag, ".dout"}, 32'(d_out), 32'(r_dout));
        check({tag, ".coll"}, 32'(collision), 32'(r_coll));
        check({tag, ".count"}, 32'(collision_count), 32'(r_cnt));
    endtask

    task automatic add(input logic c, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic cl, input logic ea,
                       input logic [3:0] eg, input logic [7:0] ed,
                       input logic ec, input logic [7:0] en);
        vec_t v;
        v.cyc = c; v.act = a; v.data = d; v.mask = m; v.clr = cl;
        v.e_act = ea; v.e_grant = eg; v.e_dout = ed; v.e_coll = ec; v.e_cnt = en;
        vecs.push_back(v);
    endtask

    localparam logic [31:0] D1 = 32'h1122BF44;
    localparam logic [31:0] D0 = 32'h11220044;
    localparam logic [31:0] D2 = 32'h11227744;

    initial begin
        logic cyc_r;
        logic [7:0] peak;
        rst_n = 1'b0;
        bus_if.ioreq = 1'b0;
        bus_if.rd = 1'b0;
        src_active = '0;
        src_data = '0;
        src_mask = '0;
        collision_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk28);
        #1;
        check("reset.active", 32'(d_out_active), 32'd0);
        check("reset.grant", 32'(grant), 32'd0);
        check("reset.dout", 32'(d_out), 32'hFF);
        check("reset.coll", 32'(collision), 32'd0);
        check("reset.count", 32'(collision_count), 32'd0);
        rst_n = 1'b1;

        // single source, cycle end, gap, retry
        add(1, 4'h2, D1, 4'hF, 0, 0, 4'h0, 8'hFF, 0, 0);
        add(1, 4'h2, D1, 4'hF, 0, 0, 4'h0, 8'hFF, 0, 0);
        add(1, 4'h2, D1, 4'hF, 0, 1, 4'h2, 8'hBF, 0, 0);
        add(1, 4'h2, D1, 4'hF, 0, 1, 4'h2, 8'hBF, 0, 0);
        add(1, 4'h2, D1, 4'hF, 0, 1, 4'h2, 8'hBF, 0, 0);
        add(0, 4'h2, D1, 4'hF, 0, 0, 4'h0, 8'hBF, 0, 0);
        add(1, 4'h2, D1, 4'hF, 0, 0, 4'h0, 8'hBF, 0, 0);
        add(1, 4'h2, D1, 4'hF, 0, 0, 4'h0, 8'hBF, 0, 0);
        add(0, 4'h2, D1, 4'hF, 0, 0, 4'h0, 8'hBF, 0, 0);
        // masked-out source -> no drive
        add(1, 4'h1, D1, 4'hE, 0, 0, 4'h0, 8'hBF, 0, 0);
        add(1, 4'h1, D1, 4'hE, 0, 0, 4'h0, 8'hBF, 0, 0);
        add(1, 4'h1, D1, 4'hE, 0, 0, 4'h0, 8'hBF, 0, 0);
        add(1, 4'h1, D1, 4'hE, 0, 0, 4'h0, 8'hBF, 0, 0);
        add(0, 4'h1, D1, 4'hE, 0, 0, 4'h0, 8'hBF, 0, 0);
        add(0, 4'h1, D1, 4'hE, 0, 0, 4'h0, 8'hBF, 0, 0);
        // short cycle
        add(1, 4'h2, D1, 4'hF, 0, 0, 4'h0, 8'hBF, 0, 0);
        add(0, 4'h2, D1, 4'hF, 0, 0, 4'h0, 8'hBF, 0, 0);
        add(0, 4'h2, D1, 4'hF, 0, 0, 4'h0, 8'hBF, 0, 0);
        // collision, then frozen data while driving
        add(1, 4'h6, D2, 4'hF, 0, 0, 4'h0, 8'hBF, 0, 0);
        add(1, 4'h6, D2, 4'hF, 0, 0, 4'h0, 8'hBF, 0, 0);
        add(1, 4'h6, D2, 4'hF, 0, 1, 4'h2, 8'h77, 1, 1);
        add(1, 4'h6, D2, 4'hF, 0, 1, 4'h2, 8'h77, 0, 1);
        add(1, 4'h0, D0, 4'h0, 0, 1, 4'h2, 8'h77, 0, 1);
        add(0, 4'h0, D0, 4'hF, 0, 0, 4'h0, 8'h77, 0, 1);
        // back-to-back: first high edge falls in the gap
        add(1, 4'h4, D1, 4'hF, 0, 0, 4'h0, 8'h77, 0, 1);
        add(1, 4'h4, D1, 4'hF, 0, 0, 4'h0, 8'h77, 0, 1);
        add(1, 4'h4, D1, 4'hF, 0, 0, 4'h0, 8'h77, 0, 1);
        add(1, 4'h4, D1, 4'hF, 0, 1, 4'h4, 8'h22, 0, 1);
        add(0, 4'h4, D1, 4'hF, 1, 0, 4'h0, 8'h22, 0, 0);
        add(0, 4'h0, D1, 4'hF, 0, 0, 4'h0, 8'h22, 0, 0);

        foreach (vecs[k]) begin
            step(vecs[k].cyc, vecs[k].act, vecs[k].data, vecs[k].mask, vecs[k].clr);
            check($sformatf("vec%0d.active", k), 32'(d_out_active), 32'(vecs[k].e_act));
            check($sformatf("vec%0d.grant", k), 32'(grant), 32'(vecs[k].e_grant));
            check($sformatf("vec%0d.dout", k), 32'(d_out), 32'(vecs[k].e_dout));
            check($sformatf("vec%0d.coll", k), 32'(collision), 32'(vecs[k].e_coll));
            check($sformatf("vec%0d.count", k), 32'(collision_count), 32'(vecs[k].e_cnt));
        end

        // 300 collisions saturate the counter
        for (int n = 0; n < 300; n++) begin
            repeat (3) step(1, 4'h6, D2, 4'hF, 0);
            check("sat.pulse", 32'(collision), 32'd1);
            chk_model("sat");
            repeat (2) step(0, 4'h6, D2, 4'hF, 0);
            check("sat.nopulse", 32'(collision), 32'd0);
        end
        check("sat.final", 32'(collision_count), 32'hFF);

        // clear coincident with a collision increment
        repeat (2) step(1, 4'h6, D2, 4'hF, 0);
        step(1, 4'h6, D2, 4'hF, 1);
        check("clrwin.coll", 32'(collision), 32'd1);
        check("clrwin.count", 32'(collision_count), 32'd0);
        step(1, 4'h6, D2, 4'hF, 0);
        check("clrwin.after", 32'(collision_count), 32'd0);
        repeat (2) step(0, 4'h0, D2, 4'hF, 0);

        // build a nonzero count, then reset asynchronously mid-drive
        repeat (3) step(1, 4'h3, D1, 4'hF, 0);
        check("pre_rst.active", 32'(d_out_active), 32'd1);
        check("pre_rst.count", 32'(collision_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.active", 32'(d_out_active), 32'd0);
        check("arst.dout", 32'(d_out), 32'hFF);
        check("arst.grant", 32'(grant), 32'd0);
        check("arst.count", 32'(collision_count), 32'd0);
        #1;
        rst_n = 1'b1;
        model_reset();

        // randomized traffic against the reference model
        cyc_r = 1'b0;
        peak = 8'd0;
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] a, m;
            logic [31:0] d;
            logic cl;
            if ($urandom_range(5) == 0) cyc_r = ~cyc_r;
            a = 4'($urandom);
            m = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
            d = $urandom;
            cl = ($urandom_range(60) == 0);
            step(cyc_r, a, d, m, cl);
            chk_model($sformatf("rnd%0d", n));
            if (r_cnt > peak) peak = r_cnt;
        end
        check("rnd.saw_collisions", 32'(peak != 0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
